// File: rtl/jtgng_dual_ram_clr.sv
// Dual-port RAM with per-byte write enables and a clear sequencer that fills every word on reset or on request.
// Optional per-byte even parity storage and checking when JTGNG_RAM_PARITY_EN is defined.
module jtgng_dual_ram_clr #(
    parameter int unsigned    dw   = 16,
    parameter int unsigned    aw   = 10,
    parameter logic [dw-1:0]  FILL = '0,
    parameter int unsigned    RDW  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_req,
    output logic            busy,
    input  logic            cen_a,
    input  logic [aw-1:0]   addr_a,
    input  logic [dw-1:0]   data_a,
    input  logic [dw/8-1:0] we_a,
    output logic [dw-1:0]   q_a,
    output logic            perr_a,
    input  logic            cen_b,
    input  logic [aw-1:0]   addr_b,
    input  logic [dw-1:0]   data_b,
    input  logic [dw/8-1:0] we_b,
    output logic [dw-1:0]   q_b,
    output logic            perr_b,
    output logic            collision
);
    localparam int unsigned nb = dw / 8;
    localparam int unsigned wn = 1 << aw;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t          state_q, state_d;
    logic [aw-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            coll_q, coll_d;
    logic [dw-1:0]   qa_q, qa_d, qb_q, qb_d;
    logic [dw-1:0]   old_a, old_b, merge_a, merge_b;
    logic [nb-1:0]   wen_a, wen_b;
    logic [dw-1:0]   mem [wn];

    // Next state, read data and lane write enables
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qa_d    = qa_q;
        qb_d    = qb_q;
        coll_d  = 1'b0;
        wen_a   = '0;
        wen_b   = '0;
        old_a   = mem[addr_a];
        old_b   = mem[addr_b];
        merge_a = old_a;
        merge_b = old_b;
        for (int i = 0; i < nb; i++) begin
            if (we_a[i]) merge_a[8*i +: 8] = data_a[8*i +: 8];
            if (we_b[i]) merge_b[8*i +: 8] = data_b[8*i +: 8];
        end
        case (state_q)
            ST_CLEAR: begin
                cnt_d = aw'(cnt_q + 1'b1);
                if (cnt_q == {aw{1'b1}}) state_d = ST_READY;
            end
            default: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
                if (cen_a) begin
                    wen_a = we_a;
                    qa_d  = (RDW != 0) ? merge_a : old_a;
                end
                if (cen_b) begin
                    wen_b = we_b;
                    qb_d  = (RDW != 0) ? merge_b : old_b;
                end
                coll_d = cen_a && cen_b && (addr_a == addr_b) && (|we_a) && (|we_b);
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            coll_q  <= 1'b0;
            qa_q    <= '0;
            qb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            coll_q  <= coll_d;
            qa_q    <= qa_d;
            qb_q    <= qb_d;
        end
    end

    // B lanes first so that A's lanes take priority on a collision
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[cnt_q] <= FILL;
            end else begin
                for (int i = 0; i < nb; i++)
                    if (wen_b[i]) mem[addr_b][8*i +: 8] <= data_b[8*i +: 8];
                for (int i = 0; i < nb; i++)
                    if (wen_a[i]) mem[addr_a][8*i +: 8] <= data_a[8*i +: 8];
            end
        end
    end

`ifdef JTGNG_RAM_PARITY_EN
    logic [nb-1:0] par [wn];
    logic          perr_a_q, perr_a_d, perr_b_q, perr_b_d;

    // Lanes replaced by the same-cycle merge carry fresh parity and are not checked
    always_comb begin
        perr_a_d = perr_a_q;
        perr_b_d = perr_b_q;
        if (state_q == ST_READY) begin
            if (cen_a) begin
                perr_a_d = 1'b0;
                for (int i = 0; i < nb; i++)
                    if (!((RDW != 0) && we_a[i]) && ((^old_a[8*i +: 8]) != par[addr_a][i]))
                        perr_a_d = 1'b1;
            end
            if (cen_b) begin
                perr_b_d = 1'b0;
                for (int i = 0; i < nb; i++)
                    if (!((RDW != 0) && we_b[i]) && ((^old_b[8*i +: 8]) != par[addr_b][i]))
                        perr_b_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_a_q <= 1'b0;
            perr_b_q <= 1'b0;
        end else begin
            perr_a_q <= perr_a_d;
            perr_b_q <= perr_b_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                for (int i = 0; i < nb; i++) par[cnt_q][i] <= ^FILL[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++)
                    if (wen_b[i]) par[addr_b][i] <= ^data_b[8*i +: 8];
                for (int i = 0; i < nb; i++)
                    if (wen_a[i]) par[addr_a][i] <= ^data_a[8*i +: 8];
            end
        end
    end

    assign perr_a = perr_a_q;
    assign perr_b = perr_b_q;
`else
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

    assign busy      = busy_q;
    assign collision = coll_q;
    assign q_a       = qa_q;
    assign q_b       = qb_q;
endmodule

// File: tb/tb_jtgng_dual_ram_clr.sv
// Directed bench for jtgng_dual_ram_clr: two instances (old-data and new-data read-during-write) share stimulus.
module tb_jtgng_dual_ram_clr;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;
    localparam logic [15:0] FILLV = 16'hA5A5;

    logic        clk = 1'b0;
    logic        rst, clr_req, cen_a, cen_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic [1:0]  we_a, we_b;
    logic        busy0, busy1, coll0, coll1;
    logic        perr_a0, perr_b0, perr_a1, perr_b1;
    logic [15:0] q_a0, q_b0, q_a1, q_b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jtgng_dual_ram_clr #(.dw(DW), .aw(AW), .FILL(FILLV), .RDW(0)) dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .cen_a(cen_a), .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a0), .perr_a(perr_a0),
        .cen_b(cen_b), .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b0), .perr_b(perr_b0),
        .collision(coll0));

    jtgng_dual_ram_clr #(.dw(DW), .aw(AW), .FILL(FILLV), .RDW(1)) dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .cen_a(cen_a), .addr_a(addr_a), .data_a(data_a), .we_a(we_a), .q_a(q_a1), .perr_a(perr_a1),
        .cen_b(cen_b), .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b1), .perr_b(perr_b1),
        .collision(coll1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cen_a = 1'b0; cen_b = 1'b0; we_a = 2'b00; we_b = 2'b00; clr_req = 1'b0;
    endtask

    task automatic read_a(input logic [3:0] a);
        cen_a = 1'b1; we_a = 2'b00; addr_a = a;
        tick();
        cen_a = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; idle();
        tick(); tick();
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1 || q_a0 !== 16'h0 || q_b0 !== 16'h0 || coll0 !== 1'b0 ||
            perr_a0 !== 1'b0 || perr_b0 !== 1'b0 || q_a1 !== 16'h0 || q_b1 !== 16'h0 || coll1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state busy=%b/%b q_a=%h q_b=%h coll=%b perr=%b%b expected busy=1 q=0 coll=0 perr=0",
                     busy0, busy1, q_a0, q_b0, coll0, perr_a0, perr_b0);
        end
        rst = 1'b0;
        n = 0;
        while (busy0 === 1'b1 && n < 64) begin tick(); n++; end
        checks++;
        if (n != 16 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear_len got=%0d cycles busy1=%b expected 16 cycles", n, busy1);
        end
    endtask

    task automatic test_fill_read();
        for (int a = 0; a < 16; a++) begin
            cen_a = 1'b1; cen_b = 1'b1; addr_a = 4'(a); addr_b = 4'(15 - a);
            tick();
            checks++;
            if (q_a0 !== FILLV || q_b0 !== FILLV || q_a1 !== FILLV || q_b1 !== FILLV) begin
                errors++;
                $display("FAIL fill_read addr=%0d q_a=%h q_b=%h q_a1=%h q_b1=%h expected %h",
                         a, q_a0, q_b0, q_a1, q_b1, FILLV);
            end
        end
        idle();
        addr_a = 4'd9;
        tick();
        checks++;
        if (q_a0 !== FILLV || perr_a0 !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_cen q_a=%h perr=%b expected %h 0", q_a0, perr_a0, FILLV);
        end
    endtask

    task automatic test_rdw();
        cen_a = 1'b1; addr_a = 4'd3; data_a = 16'h1234; we_a = 2'b11;
        tick();
        checks++;
        if (q_a0 !== 16'hA5A5 || q_a1 !== 16'h1234) begin
            errors++;
            $display("FAIL rdw_full q_a0=%h q_a1=%h expected a5a5 1234", q_a0, q_a1);
        end
        data_a = 16'hFFCC; we_a = 2'b01;
        tick();
        checks++;
        if (q_a0 !== 16'h1234 || q_a1 !== 16'h12CC) begin
            errors++;
            $display("FAIL rdw_byte q_a0=%h q_a1=%h expected 1234 12cc", q_a0, q_a1);
        end
        idle();
        read_a(4'd3);
        checks++;
        if (q_a0 !== 16'h12CC || q_a1 !== 16'h12CC) begin
            errors++;
            $display("FAIL rdw_readback q_a0=%h q_a1=%h expected 12cc", q_a0, q_a1);
        end
    endtask

    task automatic test_collision();
        cen_a = 1'b1; cen_b = 1'b1; addr_a = 4'd7; addr_b = 4'd7;
        data_a = 16'hAAAA; we_a = 2'b10; data_b = 16'h5555; we_b = 2'b11;
        tick();
        idle();
        checks++;
        if (coll0 !== 1'b1 || coll1 !== 1'b1) begin
            errors++;
            $display("FAIL collision_pulse got=%b/%b expected 1", coll0, coll1);
        end
        tick();
        checks++;
        if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
            errors++;
            $display("FAIL collision_clear got=%b/%b expected 0", coll0, coll1);
        end
        read_a(4'd7);
        checks++;
        if (q_a0 !== 16'hAA55 || q_a1 !== 16'hAA55) begin
            errors++;
            $display("FAIL collision_merge q_a0=%h q_a1=%h expected aa55", q_a0, q_a1);
        end
    endtask

    task automatic test_cross_port();
        cen_a = 1'b1; addr_a = 4'd5; data_a = 16'h0F0F; we_a = 2'b11;
        cen_b = 1'b1; addr_b = 4'd5; we_b = 2'b00;
        tick();
        cen_a = 1'b0; we_a = 2'b00;
        checks++;
        if (q_b0 !== 16'hA5A5 || q_b1 !== 16'hA5A5 || coll0 !== 1'b0) begin
            errors++;
            $display("FAIL cross_old q_b0=%h q_b1=%h coll=%b expected a5a5 a5a5 0", q_b0, q_b1, coll0);
        end
        tick();
        idle();
        checks++;
        if (q_b0 !== 16'h0F0F || q_b1 !== 16'h0F0F) begin
            errors++;
            $display("FAIL cross_new q_b0=%h q_b1=%h expected 0f0f", q_b0, q_b1);
        end
    endtask

    task automatic test_clear();
        int n;
        read_a(4'd3);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL clr_start busy=%b/%b expected 1", busy0, busy1);
        end
        cen_a = 1'b1; addr_a = 4'd0; data_a = 16'hDEAD; we_a = 2'b11;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            clr_req = (k == 2);
            tick();
            n++;
        end
        idle();
        checks++;
        if (q_a0 !== 16'h12CC || q_a1 !== 16'h12CC || coll0 !== 1'b0) begin
            errors++;
            $display("FAIL clr_hold q_a0=%h q_a1=%h coll=%b expected 12cc 12cc 0", q_a0, q_a1, coll0);
        end
        while (busy0 === 1'b1 && n < 64) begin tick(); n++; end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL clr_len got=%0d cycles expected 16", n);
        end
        for (int k = 0; k < 3; k++) begin
            automatic logic [3:0] ad = (k == 0) ? 4'd0 : ((k == 1) ? 4'd3 : 4'd7);
            read_a(ad);
            checks++;
            if (q_a0 !== FILLV || q_a1 !== FILLV) begin
                errors++;
                $display("FAIL clr_content addr=%0d q_a0=%h q_a1=%h expected %h", ad, q_a0, q_a1, FILLV);
            end
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (busy0 !== 1'b1 || q_a0 !== 16'h0 || q_a1 !== 16'h0) begin
            errors++;
            $display("FAIL clr_rst_state busy=%b q_a0=%h q_a1=%h expected 1 0 0", busy0, q_a0, q_a1);
        end
        n = 0;
        while (busy0 === 1'b1 && n < 64) begin tick(); n++; end
        checks++;
        if (n != 16 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL clr_rst_len got=%0d cycles expected 16", n);
        end
    endtask

    task automatic test_parity();
`ifdef JTGNG_RAM_PARITY_EN
        dut0.mem[2][3] = ~dut0.mem[2][3];
        read_a(4'd2);
        checks++;
        if (perr_a0 !== 1'b1 || q_a0 !== 16'hA5AD) begin
            errors++;
            $display("FAIL parity_err perr=%b q_a=%h expected 1 a5ad", perr_a0, q_a0);
        end
        read_a(4'd4);
        checks++;
        if (perr_a0 !== 1'b0 || q_a0 !== FILLV) begin
            errors++;
            $display("FAIL parity_ok perr=%b q_a=%h expected 0 %h", perr_a0, q_a0, FILLV);
        end
`else
        read_a(4'd2);
        checks++;
        if (perr_a0 !== 1'b0 || perr_a1 !== 1'b0 || perr_b0 !== 1'b0 || q_a0 !== FILLV) begin
            errors++;
            $display("FAIL parity_off perr=%b%b%b q_a=%h expected 000 %h", perr_a0, perr_a1, perr_b0, q_a0, FILLV);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; clr_req = 1'b0; cen_a = 1'b0; cen_b = 1'b0;
        addr_a = '0; addr_b = '0; data_a = '0; data_b = '0; we_a = '0; we_b = '0;
        test_reset();
        test_fill_read();
        test_rdw();
        test_collision();
        test_cross_port();
        test_clear();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
